// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR engine: FSM encoding, width helper
// and saturation bounds.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    // Number of bits needed to index 'value' distinct entries.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic longint sat_max_f(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min_f(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample history for the serial FIR: shift register with enable and an
// index-addressed read port feeding the multiplier.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAPS   = 8,
    parameter int IDX_W  = clog2_f(TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] x_q [TAPS];
    logic [DATA_W-1:0] x_d [TAPS];

    // Next history: newest sample enters at x[0], oldest falls off the end.
    always_comb begin
        x_d = x_q;
        if (shift_en) begin
            x_d[0] = din;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end else begin
            x_d = x_q;
        end
    end

    // History registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            x_q <= x_d;
        end
    end

    // Read mux; an index past the last tap reads as zero.
    always_comb begin
        rd_data = '0;
        if (32'(rd_idx) < TAPS) begin
            rd_data = x_q[rd_idx];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed direct-form FIR: one signed MAC per clock over TAPS cycles,
// saturated result held under valid/ready until the consumer takes it.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    input  logic                       coef_we,
    input  logic [clog2_f(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    output logic                       busy
);

    localparam int     IDX_W   = clog2_f(TAPS);
    localparam int     PROD_W  = DATA_W + COEF_W;
    localparam int     ACC_W   = PROD_W + IDX_W;
    localparam longint SAT_MAX = sat_max_f(OUT_W);
    localparam longint SAT_MIN = sat_min_f(OUT_W);

    fir_state_e               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [COEF_W-1:0]        coef_q [TAPS];
    logic [COEF_W-1:0]        coef_d [TAPS];
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;

    logic                     shift_en_s;
    logic                     coef_hit_s;
    logic [DATA_W-1:0]        x_rd_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [ACC_W-1:0]  acc_shift_s;
    logic signed [63:0]       acc_wide_s;
    logic [OUT_W-1:0]         sat_s;

    fir_delay_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .IDX_W  (IDX_W)
    ) u_delay_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en_s),
        .din      (in_data),
        .rd_idx   (idx_q),
        .rd_data  (x_rd_s)
    );

    // MAC datapath and output saturation; the accumulator is wide enough never to wrap.
    always_comb begin
        prod_s      = PROD_W'($signed(x_rd_s)) * PROD_W'($signed(coef_q[idx_q]));
        acc_sum_s   = acc_q + ACC_W'(prod_s);
        acc_shift_s = acc_sum_s >>> SHIFT;
        acc_wide_s  = 64'(acc_shift_s);
        if (acc_wide_s > SAT_MAX) begin
            sat_s = OUT_W'(SAT_MAX);
        end else if (acc_wide_s < SAT_MIN) begin
            sat_s = OUT_W'(SAT_MIN);
        end else begin
            sat_s = OUT_W'(acc_wide_s);
        end
    end

    // Coefficients only change while idle, so a running sum never sees a mixed set.
    always_comb begin
        coef_hit_s = coef_we && (state_q == ST_IDLE) && (32'(coef_addr) < TAPS);
        coef_d     = coef_q;
        if (coef_hit_s) begin
            coef_d[coef_addr] = coef_wdata;
        end else begin
            coef_d = coef_q;
        end
    end

    // FSM next state, MAC sequencing and output handshake.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        shift_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_en_s = 1'b1;
                    acc_d      = '0;
                    idx_d      = '0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum_s;
                if (idx_q == IDX_W'(TAPS - 1)) begin
                    out_data_d  = sat_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            coef_q      <= coef_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
